// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port, fixed-latency memory between the
//            instruction-fetch requester and the load/store requester.
//            Accesses are serialised by an IDLE/ACCESS/WAIT/RESP FSM.
// Ports    : clk_i, rst_ni             clock, async active-low reset
//            if_req_i/if_addr_i        fetch request and address
//            if_gnt_o/if_rvalid_o/if_rdata_o  fetch grant, response pulse, data
//            d_req_i/d_we_i/d_addr_i/d_wdata_i  load/store request
//            d_gnt_o/d_rvalid_o/d_rdata_o       data grant, response pulse, data
//            mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o/mem_rdata_i  memory side
//            busy_o                    high whenever the FSM is not in IDLE
// Config   : `define MEM_ARB_ROUND_ROBIN_EN  alternate owners on simultaneous
//            requests; otherwise data has fixed priority over fetch.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_rvalid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [ADDR_W-1:0] d_addr_i,
    input  logic [DATA_W-1:0] d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    generate
        if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
            $error("mem_port_arbiter: LATENCY must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic       OWN_FETCH = 1'b0;
    localparam logic       OWN_DATA  = 1'b1;
    localparam logic [3:0] LAT_M1    = 4'(LATENCY - 1);

    state_t            state_q;
    logic [3:0]        cnt_q;
    logic              owner_q;
    logic              we_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_rvalid_q;
    logic              d_rvalid_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] d_rdata_q;
    logic              busy_q;

    logic              pick_data;
    logic              gnt_ok;
    logic              gnt_any;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic              last_owner_q;
    // Single requests win outright; a tie goes to whoever did not own last.
    assign pick_data = d_req_i & (~if_req_i | (last_owner_q == OWN_FETCH));
`else
    // Data always wins: a pending load/store already stalls the core.
    assign pick_data = d_req_i;
`endif

    // Grants are only offered in IDLE; gating with rst_ni keeps every output
    // low while reset is asserted even if a requester holds req high.
    assign gnt_ok   = (state_q == S_IDLE) & rst_ni;
    assign d_gnt_o  = gnt_ok & pick_data;
    assign if_gnt_o = gnt_ok & if_req_i & ~pick_data;
    assign gnt_any  = d_gnt_o | if_gnt_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            owner_q      <= OWN_FETCH;
            we_q         <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rvalid_q  <= 1'b0;
            d_rvalid_q   <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            busy_q       <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            last_owner_q <= OWN_FETCH;
`endif
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_any) begin
                        owner_q     <= pick_data ? OWN_DATA : OWN_FETCH;
                        we_q        <= pick_data & d_we_i;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= pick_data & d_we_i;
                        mem_addr_q  <= pick_data ? d_addr_i : if_addr_i;
                        mem_wdata_q <= pick_data ? d_wdata_i : '0;
                        busy_q      <= 1'b1;
                        state_q     <= S_ACCESS;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                        last_owner_q <= pick_data ? OWN_DATA : OWN_FETCH;
`endif
                    end
                end
                S_ACCESS: begin
                    // Memory-side outputs are only non-zero during ACCESS.
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    cnt_q       <= LAT_M1;
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        // This is the cycle mem_rdata becomes valid.
                        if (owner_q == OWN_DATA) begin
                            if (!we_q) begin
                                d_rdata_q <= mem_rdata_i;
                            end
                            d_rvalid_q <= 1'b1;
                        end else begin
                            if_rdata_q  <= mem_rdata_i;
                            if_rvalid_q <= 1'b1;
                        end
                        state_q <= S_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign if_rvalid_o = if_rvalid_q;
    assign if_rdata_o  = if_rdata_q;
    assign d_rvalid_o  = d_rvalid_q;
    assign d_rdata_o   = d_rdata_q;
    assign mem_en_o    = mem_en_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign busy_o      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed self-checking bench for mem_port_arbiter. A small
//            memory model returns addr ^ 0x0051_0083 only in the single cycle
//            LAT cycles after mem_en, and a junk value at all other times.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_if_rdata;
    logic [31:0] exp_d_rdata;

    mem_port_arbiter #(
        .LATENCY(LAT),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_gnt_o   (if_gnt),
        .if_rvalid_o(if_rvalid),
        .if_rdata_o (if_rdata),
        .d_req_i    (d_req),
        .d_we_i     (d_we),
        .d_addr_i   (d_addr),
        .d_wdata_i  (d_wdata),
        .d_gnt_o    (d_gnt),
        .d_rvalid_o (d_rvalid),
        .d_rdata_o  (d_rdata),
        .mem_en_o   (mem_en),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data valid only in cycle (mem_en cycle + LAT).
    int          mem_cd;
    logic [31:0] mem_addr_l;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return a ^ 32'h0051_0083;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_cd     <= 0;
            mem_addr_l <= 32'h0;
        end else if (mem_en) begin
            mem_cd     <= LAT;
            mem_addr_l <= mem_addr;
        end else if (mem_cd > 0) begin
            mem_cd <= mem_cd - 1;
        end
    end

    assign mem_rdata = (mem_cd == 1) ? mem_val(mem_addr_l) : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req  = 1'b0;
        if_addr = 32'hFFFF_FFFF;
        d_req   = 1'b0;
        d_we    = 1'b1;
        d_addr  = 32'hFFFF_FFFF;
        d_wdata = 32'hFFFF_FFFF;
    endtask

    // One complete transaction starting in an IDLE cycle.
    task automatic do_txn(input bit is_d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata);
        if (is_d) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        #1;
        check("gnt_if_c0", 32'(if_gnt), 32'(!is_d));
        check("gnt_d_c0", 32'(d_gnt), 32'(is_d));
        check("busy_c0", 32'(busy), 32'd0);
        next_cycle();
        idle_inputs();
        #1;
        check("mem_en_c1", 32'(mem_en), 32'd1);
        check("mem_we_c1", 32'(mem_we), 32'(is_d & we));
        check("mem_addr_c1", mem_addr, addr);
        check("mem_wdata_c1", mem_wdata, (is_d && we) ? wdata : 32'h0);
        check("busy_c1", 32'(busy), 32'd1);
        for (int k = 2; k <= LAT + 1; k++) begin
            next_cycle();
            #1;
            check("mem_en_wait", 32'(mem_en), 32'd0);
            check("mem_addr_wait", mem_addr, 32'h0);
            check("rvalid_wait", 32'({if_rvalid, d_rvalid}), 32'd0);
            check("busy_wait", 32'(busy), 32'd1);
        end
        next_cycle();
        #1;
        if (is_d) begin
            if (!we) exp_d_rdata = mem_val(addr);
        end else begin
            exp_if_rdata = mem_val(addr);
        end
        check("if_rvalid_resp", 32'(if_rvalid), 32'(!is_d));
        check("d_rvalid_resp", 32'(d_rvalid), 32'(is_d));
        check("if_rdata_resp", if_rdata, exp_if_rdata);
        check("d_rdata_resp", d_rdata, exp_d_rdata);
        check("busy_resp", 32'(busy), 32'd1);
        next_cycle();
        #1;
        check("busy_idle", 32'(busy), 32'd0);
        check("rvalid_idle", 32'({if_rvalid, d_rvalid}), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stray;
        idle_inputs();
        exp_if_rdata = 32'h0;
        exp_d_rdata  = 32'h0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_en", 32'(mem_en), 32'd0);
        check("rst_gnt", 32'({if_gnt, d_gnt}), 32'd0);
        check("rst_rvalid", 32'({if_rvalid, d_rvalid}), 32'd0);
        check("rst_if_rdata", if_rdata, 32'h0);
        check("rst_d_rdata", d_rdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();

        // Both requesters held for three transactions, first tie after reset.
        if_req = 1'b1; if_addr = 32'h40;
        d_req  = 1'b1; d_addr  = 32'h80; d_we = 1'b0; d_wdata = 32'h0;
        stray = 0;
        for (int c = 0; c <= 10; c++) begin
            #1;
            if (c == 0 || c == 10) begin
                check("sim_d_gnt", 32'(d_gnt), 32'd1);
                check("sim_if_gnt", 32'(if_gnt), 32'd0);
            end else if (c == 5) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
                check("sim_d_gnt5", 32'(d_gnt), 32'd0);
                check("sim_if_gnt5", 32'(if_gnt), 32'd1);
`else
                check("sim_d_gnt5", 32'(d_gnt), 32'd1);
                check("sim_if_gnt5", 32'(if_gnt), 32'd0);
`endif
            end else if (if_gnt || d_gnt) begin
                stray++;
            end
            next_cycle();
        end
        idle_inputs();
        repeat (LAT + 3) next_cycle();
        check("sim_stray_gnt", 32'(stray), 32'd0);
        exp_d_rdata = mem_val(32'h80);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_if_rdata = mem_val(32'h40);
`endif
        check("sim_d_rdata", d_rdata, exp_d_rdata);
        check("sim_if_rdata", if_rdata, exp_if_rdata);

        // Single fetch, load, then store (d_rdata must survive the store).
        do_txn(1'b0, 1'b0, 32'h0000_0010, 32'h0);
        check("fetch_value", if_rdata, 32'h0051_0093);
        do_txn(1'b1, 1'b0, 32'h0000_0200, 32'h0);
        do_txn(1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF);

        // Fetch arriving while a load is in flight.
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        #1;
        check("busy_d_gnt", 32'(d_gnt), 32'd1);
        next_cycle();
        idle_inputs();
        next_cycle();
        if_req = 1'b1; if_addr = 32'h44;
        for (int c = 2; c <= 4; c++) begin
            #1;
            check("busy_no_gnt", 32'({if_gnt, d_gnt}), 32'd0);
            next_cycle();
        end
        check("busy_c4_rvalid", 32'(d_rvalid), 32'd0);
        #1;
        exp_d_rdata = mem_val(32'h300);
        check("busy_c5_if_gnt", 32'(if_gnt), 32'd1);
        check("busy_c5_busy", 32'(busy), 32'd0);
        next_cycle();
        idle_inputs();
        repeat (LAT + 1) next_cycle();
        exp_if_rdata = mem_val(32'h44);
        check("busy_if_rvalid", 32'(if_rvalid), 32'd1);
        check("busy_if_rdata", if_rdata, exp_if_rdata);
        check("busy_d_rdata", d_rdata, exp_d_rdata);
        next_cycle();

        // Asynchronous reset while a fetch sits in WAIT.
        if_req = 1'b1; if_addr = 32'h20;
        #1;
        check("rmid_gnt", 32'(if_gnt), 32'd1);
        next_cycle();
        idle_inputs();
        next_cycle();
        #2;
        rst_n = 1'b0;
        #1;
        check("rmid_busy", 32'(busy), 32'd0);
        check("rmid_mem_en", 32'(mem_en), 32'd0);
        check("rmid_if_rdata", if_rdata, 32'h0);
        check("rmid_d_rdata", d_rdata, 32'h0);
        exp_if_rdata = 32'h0;
        exp_d_rdata  = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            if (if_rvalid || d_rvalid || busy) stray++;
        end
        check("rmid_no_rvalid", 32'(stray), 32'd0);
        do_txn(1'b0, 1'b0, 32'h0000_0024, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the instruction-fetch requester and the load/store requester of the RISC-V core.
- Used when IMEM and DMEM are merged into one unified memory.
- Serialises accesses with an IDLE/ACCESS/WAIT/RESP state machine.
- Provides a per-requester grant and a one-cycle response pulse; `busy` drives the core's PC-stall logic.

Parameters:
- LATENCY, 2, cycles from the memory-enable cycle until mem_rdata is valid; legal range 1..15.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_req  in  1  fetch read request; held until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched instruction.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  one-cycle pulse: load data valid, or store complete.
- d_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access strobe, exactly one cycle per transaction.
- mem_we  out  1  memory write enable, qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid LATENCY cycles after mem_en.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE; all outputs 0; capture registers 0; last_owner = FETCH.
  - Reset mid-transaction abandons it: no rvalid is ever produced for it.
- IDLE:
  - If any request is present, pick a winner and assert its gnt combinationally (one gnt at most).
  - At the clock edge, capture the winner's addr, we, wdata and owner; go to ACCESS.
  - No request: stay in IDLE.
  - A gnt is issued only in IDLE.
- ACCESS (1 cycle):
  - mem_en = 1; mem_we = captured we (0 for fetch); mem_addr/mem_wdata from capture registers.
  - Load counter with LATENCY-1; go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - In the cycle where the counter equals 0 (ACCESS cycle + LATENCY), sample mem_rdata into the hold register and go to RESP.
  - With LATENCY = 1, WAIT lasts exactly 1 cycle.
- RESP (1 cycle):
  - Pulse the owner's rvalid.
  - Owner's rdata = hold register; the other requester's rdata keeps its previous value.
  - Store: d_rvalid pulses as completion; d_rdata is unchanged.
  - Go to IDLE.
- Timing:
  - Latency: gnt cycle to rvalid cycle = LATENCY+2 cycles.
  - Back-to-back throughput: one transaction per LATENCY+3 cycles.
- Outputs outside their defining state: mem_en, mem_we, mem_addr and mem_wdata are 0.
- Requester rule: if_*/d_* inputs are don't-care once gnt is taken. Requesters must not drop req before gnt; the arbiter does not check this.
- Counter width is 4 bits. LATENCY outside 1..15 is a configuration error, flagged by an elaboration-time check.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined:
  - If both requests are present in IDLE, grant the requester that is not last_owner.
  - last_owner updates at every grant.
  - Single requests are granted immediately, regardless of last_owner.
  - The first simultaneous request after reset goes to data.
- Undefined:
  - Fixed priority: data always beats fetch; last_owner is not implemented.
  - Continuous data requests starve fetch, by design, because a load/store stalls the core.

Test Plan (LATENCY=2):
- Single fetch:
  - Stimulus: if_req=1, if_addr=0x0000_0010 in IDLE; memory returns 0x0051_0093.
  - Response: if_gnt in cycle 0; mem_en=1, mem_addr=0x10, mem_we=0 in cycle 1; if_rvalid=1, if_rdata=0x0051_0093 in cycle 4; busy high in cycles 1-4.
- Store:
  - Stimulus: d_req=1, d_we=1, d_addr=0x100, d_wdata=0xDEAD_BEEF.
  - Response: mem_en=mem_we=1, mem_wdata=0xDEAD_BEEF in cycle 1; d_rvalid in cycle 4; d_rdata unchanged.
- Simultaneous requests, if_req=d_req=1 held for three transactions:
  - Fixed priority: d_gnt at cycles 0, 5 and 10; no if_gnt.
  - MEM_ARB_ROUND_ROBIN_EN: d_gnt at 0, if_gnt at 5, d_gnt at 10.
- Request during busy:
  - Stimulus: if_req asserted in cycle 2 of a data transaction.
  - Response: if_gnt is held off until IDLE in cycle 5; no gnt while busy=1.
- Reset mid-operation:
  - Stimulus: rst_n=0 asynchronously during WAIT.
  - Response: all outputs 0 immediately, no rvalid afterwards; after release, a fresh fetch completes normally with rvalid 4 cycles after gnt.
- LATENCY=1 rebuild:
  - Response: gnt-to-rvalid = 3 cycles; mem_rdata is sampled exactly 1 cycle after mem_en.
